// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: data_ok wait, load align/merge, flush discard, decode forwarding
// Optional: define MS_LOAD_FWD_EN to forward load data to decode in the data_ok cycle.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 161,
    parameter int MS_TO_WS_BUS_WD = 152
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_req_fire,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_dataok,
    input  logic                       ws_handle_ex,
    output logic                       ms_handle_ex,
    output logic                       ms_fwd_valid,
    output logic [4:0]                 ms_fwd_dest,
    output logic [31:0]                ms_fwd_data,
    output logic                       ms_fwd_block
);

    logic                       ms_valid_q;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic                       wait_data_q;
    logic                       data_buf_valid_q;
    logic [31:0]                data_buf_q;
    logic [1:0]                 discard_cnt_q;
    logic [1:0]                 discard_cnt_d;

    logic        ex, bd, eret, mtc0, res_from_cp0, res_from_mem, gr_we;
    logic        lb, lbu, lh, lhu, lwl, lwr;
    logic [4:0]  exccode, dest;
    logic [31:0] badvaddr, rt_value, alu_result, pc;
    logic [7:0]  cp0_addr;
    logic [1:0]  addr_low;

    assign ex           = es_bus_q[160];
    assign exccode      = es_bus_q[159:155];
    assign bd           = es_bus_q[154];
    assign badvaddr     = es_bus_q[153:122];
    assign eret         = es_bus_q[121];
    assign mtc0         = es_bus_q[120];
    assign cp0_addr     = es_bus_q[119:112];
    assign rt_value     = es_bus_q[111:80];
    assign res_from_cp0 = es_bus_q[79];
    assign res_from_mem = es_bus_q[78];
    assign addr_low     = es_bus_q[77:76];
    assign lb           = es_bus_q[75];
    assign lbu          = es_bus_q[74];
    assign lh           = es_bus_q[73];
    assign lhu          = es_bus_q[72];
    assign lwl          = es_bus_q[71];
    assign lwr          = es_bus_q[70];
    assign gr_we        = es_bus_q[69];
    assign dest         = es_bus_q[68:64];
    assign alu_result   = es_bus_q[63:32];
    assign pc           = es_bus_q[31:0];

    // A response is ours only once every response owed to flushed requests has drained.
    logic accept_ok, capture_ok, ms_ready_go, pending_lost, fwd_avail;
    assign accept_ok    = data_sram_dataok && (discard_cnt_q == 2'd0);
    assign capture_ok   = ms_valid_q && wait_data_q && !data_buf_valid_q && accept_ok;
    assign ms_ready_go  = !wait_data_q || data_buf_valid_q || accept_ok;
    assign ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign pending_lost = ms_valid_q && wait_data_q && !data_buf_valid_q && !accept_ok;

`ifdef MS_LOAD_FWD_EN
    assign fwd_avail = !wait_data_q || data_buf_valid_q || accept_ok;
`else
    assign fwd_avail = !wait_data_q || data_buf_valid_q;
`endif

    always_comb begin
        logic [1:0] inc;
        logic [1:0] dec;
        inc = {1'b0, ws_handle_ex && pending_lost} + {1'b0, ws_handle_ex && es_req_fire};
        dec = {1'b0, data_sram_dataok && (discard_cnt_q != 2'd0)};
        discard_cnt_d = discard_cnt_q + inc - dec;
    end

    logic [31:0] ld, load_result, final_result;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    assign ld   = data_buf_valid_q ? data_buf_q : data_sram_rdata;
    assign ld_h = addr_low[1] ? ld[31:16] : ld[15:0];

    always_comb begin
        ld_b = ld[7:0];
        case (addr_low)
            2'd0: ld_b = ld[7:0];
            2'd1: ld_b = ld[15:8];
            2'd2: ld_b = ld[23:16];
            2'd3: ld_b = ld[31:24];
            default: ld_b = ld[7:0];
        endcase
    end

    always_comb begin
        load_result = ld;
        if (lb)
            load_result = {{24{ld_b[7]}}, ld_b};
        else if (lbu)
            load_result = {24'd0, ld_b};
        else if (lh)
            load_result = {{16{ld_h[15]}}, ld_h};
        else if (lhu)
            load_result = {16'd0, ld_h};
        else if (lwl) begin
            case (addr_low)
                2'd0: load_result = {ld[7:0], rt_value[23:0]};
                2'd1: load_result = {ld[15:0], rt_value[15:0]};
                2'd2: load_result = {ld[23:0], rt_value[7:0]};
                default: load_result = ld;
            endcase
        end else if (lwr) begin
            case (addr_low)
                2'd0: load_result = ld;
                2'd1: load_result = {rt_value[31:24], ld[31:8]};
                2'd2: load_result = {rt_value[31:16], ld[31:16]};
                default: load_result = {rt_value[31:8], ld[31:24]};
            endcase
        end
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ms_to_ws_bus = {ex, exccode, bd, badvaddr, eret, mtc0, cp0_addr, rt_value,
                           res_from_cp0, gr_we, dest, final_result, pc};

    assign ms_handle_ex = ms_valid_q && (ex || eret);
    assign ms_fwd_valid = ms_valid_q && gr_we && !ex;
    assign ms_fwd_dest  = dest;
    assign ms_fwd_data  = final_result;
    assign ms_fwd_block = ms_valid_q && res_from_mem && !ex && !fwd_avail;

    // data_buf is captured on every accepted response, even if the instruction leaves this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q       <= 1'b0;
            es_bus_q         <= '0;
            wait_data_q      <= 1'b0;
            data_buf_valid_q <= 1'b0;
            data_buf_q       <= 32'd0;
            discard_cnt_q    <= 2'd0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
            if (capture_ok) begin
                data_buf_q       <= data_sram_rdata;
                data_buf_valid_q <= 1'b1;
            end
            if (ws_handle_ex) begin
                ms_valid_q       <= 1'b0;
                wait_data_q      <= 1'b0;
                data_buf_valid_q <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid_q       <= es_to_ms_valid;
                wait_data_q      <= es_to_ms_valid && es_req_fire;
                data_buf_valid_q <= 1'b0;
                if (es_to_ms_valid)
                    es_bus_q <= es_to_ms_bus;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [160:0] es_to_ms_bus;
    logic         es_req_fire;
    logic         ms_to_ws_valid;
    logic [151:0] ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_dataok;
    logic         ws_handle_ex;
    logic         ms_handle_ex;
    logic         ms_fwd_valid;
    logic [4:0]   ms_fwd_dest;
    logic [31:0]  ms_fwd_data;
    logic         ms_fwd_block;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ws_allowin       (ws_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .es_req_fire      (es_req_fire),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_dataok (data_sram_dataok),
        .ws_handle_ex     (ws_handle_ex),
        .ms_handle_ex     (ms_handle_ex),
        .ms_fwd_valid     (ms_fwd_valid),
        .ms_fwd_dest      (ms_fwd_dest),
        .ms_fwd_data      (ms_fwd_data),
        .ms_fwd_block     (ms_fwd_block)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b010000;
    localparam logic [5:0] OP_LH  = 6'b001000;
    localparam logic [5:0] OP_LHU = 6'b000100;
    localparam logic [5:0] OP_LWL = 6'b000010;
    localparam logic [5:0] OP_LWR = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [160:0] mk_bus(input logic [5:0] op, input logic rfm, input logic ex,
                                            input logic [4:0] dest, input logic [31:0] alu,
                                            input logic [31:0] rt, input logic [31:0] pc);
        logic [160:0] b;
        b = '0;
        b[160]     = ex;
        b[111:80]  = rt;
        b[78]      = rfm;
        b[77:76]   = alu[1:0];
        b[75:70]   = op;
        b[69]      = 1'b1;
        b[68:64]   = dest;
        b[63:32]   = alu;
        b[31:0]    = pc;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [160:0] bus, input logic fire);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        es_req_fire    = fire;
        tick();
        es_to_ms_valid = 1'b0;
        es_req_fire    = 1'b0;
        es_to_ms_bus   = '0;
    endtask

    logic [160:0] vec_bus [6];
    logic [31:0]  vec_rd  [6];
    logic [31:0]  vec_exp [6];

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        es_req_fire = 1'b0; data_sram_rdata = 32'd0; data_sram_dataok = 1'b0; ws_handle_ex = 1'b0;
        #2;
        check("rst_allowin", {31'd0, ms_allowin}, 32'd1);
        check("rst_to_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("rst_handle_ex", {31'd0, ms_handle_ex}, 32'd0);
        check("rst_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
        check("rst_fwd_block", {31'd0, ms_fwd_block}, 32'd0);
        tick(); tick();
        reset = 1'b0;

        // LW with data_ok three cycles after load
        do_load(mk_bus(OP_LW, 1'b1, 1'b0, 5'd3, 32'h0000_1000, 32'd0, 32'hBFC0_0100), 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("lw_wait_block", {31'd0, ms_fwd_block}, 32'd1);
            check("lw_wait_valid", {31'd0, ms_to_ws_valid}, 32'd0);
            check("lw_wait_allowin", {31'd0, ms_allowin}, 32'd0);
            tick();
        end
        data_sram_dataok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_dataok_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("lw_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        check("lw_pc", ms_to_ws_bus[31:0], 32'hBFC0_0100);
        check("lw_allowin", {31'd0, ms_allowin}, 32'd1);
        tick();
        data_sram_dataok = 1'b0;
        #1;
        check("lw_gone", {31'd0, ms_to_ws_valid}, 32'd0);

        // byte/half/word-merge loads
        vec_bus[0] = mk_bus(OP_LB,  1'b1, 1'b0, 5'd4, 32'h0000_2001, 32'd0, 32'h100);
        vec_bus[1] = mk_bus(OP_LBU, 1'b1, 1'b0, 5'd4, 32'h0000_2003, 32'd0, 32'h104);
        vec_bus[2] = mk_bus(OP_LH,  1'b1, 1'b0, 5'd4, 32'h0000_2002, 32'd0, 32'h108);
        vec_bus[3] = mk_bus(OP_LHU, 1'b1, 1'b0, 5'd4, 32'h0000_2000, 32'd0, 32'h10C);
        vec_bus[4] = mk_bus(OP_LWL, 1'b1, 1'b0, 5'd4, 32'h0000_2001, 32'h1122_3344, 32'h110);
        vec_bus[5] = mk_bus(OP_LWR, 1'b1, 1'b0, 5'd4, 32'h0000_2002, 32'h1122_3344, 32'h114);
        vec_rd[0] = 32'h8081_F2F3; vec_exp[0] = 32'hFFFF_FFF2;
        vec_rd[1] = 32'h8081_F2F3; vec_exp[1] = 32'h0000_0080;
        vec_rd[2] = 32'h8081_F2F3; vec_exp[2] = 32'hFFFF_8081;
        vec_rd[3] = 32'h8081_F2F3; vec_exp[3] = 32'h0000_F2F3;
        vec_rd[4] = 32'hAABB_CCDD; vec_exp[4] = 32'hCCDD_3344;
        vec_rd[5] = 32'hAABB_CCDD; vec_exp[5] = 32'h1122_AABB;
        for (int i = 0; i < 6; i++) begin
            do_load(vec_bus[i], 1'b1);
            data_sram_dataok = 1'b1; data_sram_rdata = vec_rd[i];
            #1;
            check($sformatf("ld%0d_valid", i), {31'd0, ms_to_ws_valid}, 32'd1);
            check($sformatf("ld%0d_result", i), ms_to_ws_bus[63:32], vec_exp[i]);
            tick();
            data_sram_dataok = 1'b0;
        end

        // response while writeback stalls: buffered and held
        do_load(mk_bus(OP_LW, 1'b1, 1'b0, 5'd6, 32'h0000_3000, 32'd0, 32'h200), 1'b1);
        ws_allowin = 1'b0; data_sram_dataok = 1'b1; data_sram_rdata = 32'h1234_5678;
        #1;
        check("stall_allowin0", {31'd0, ms_allowin}, 32'd0);
        tick();
        data_sram_dataok = 1'b0; data_sram_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hold_allowin", {31'd0, ms_allowin}, 32'd0);
            check("stall_hold_result", ms_to_ws_bus[63:32], 32'h1234_5678);
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        check("stall_release_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("stall_release_result", ms_to_ws_bus[63:32], 32'h1234_5678);
        check("stall_release_allowin", {31'd0, ms_allowin}, 32'd1);
        tick();

        // flush with one pending response plus a newly fired request: two to discard
        do_load(mk_bus(OP_LW, 1'b1, 1'b0, 5'd7, 32'h0000_4000, 32'd0, 32'h300), 1'b1);
        ws_handle_ex = 1'b1; es_req_fire = 1'b1;
        #1;
        check("flush_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        tick();
        ws_handle_ex = 1'b0; es_req_fire = 1'b0;
        #1;
        check("flush_empty_allowin", {31'd0, ms_allowin}, 32'd1);
        do_load(mk_bus(OP_LW, 1'b1, 1'b0, 5'd8, 32'h0000_5000, 32'd0, 32'h400), 1'b1);
        data_sram_dataok = 1'b1; data_sram_rdata = 32'hBAD0_0001;
        #1;
        check("discard1_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        tick();
        data_sram_rdata = 32'hBAD0_0002;
        #1;
        check("discard2_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("discard2_block", {31'd0, ms_fwd_block}, 32'd1);
        tick();
        data_sram_rdata = 32'h600D_F00D;
        #1;
        check("after_discard_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("after_discard_result", ms_to_ws_bus[63:32], 32'h600D_F00D);
        tick();
        data_sram_dataok = 1'b0;

        // non-memory instruction: ready next cycle, forwards ALU value
        do_load(mk_bus(OP_LW, 1'b0, 1'b0, 5'd5, 32'hCAFE_0001, 32'd0, 32'h500), 1'b0);
        #1;
        check("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("alu_result", ms_to_ws_bus[63:32], 32'hCAFE_0001);
        check("alu_fwd_valid", {31'd0, ms_fwd_valid}, 32'd1);
        check("alu_fwd_dest", {27'd0, ms_fwd_dest}, 32'd5);
        check("alu_fwd_data", ms_fwd_data, 32'hCAFE_0001);
        check("alu_fwd_block", {31'd0, ms_fwd_block}, 32'd0);
        tick();

        // excepting load without a request: ready, no forward
        do_load(mk_bus(OP_LW, 1'b1, 1'b1, 5'd9, 32'h0000_6001, 32'd0, 32'h600), 1'b0);
        #1;
        check("ex_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        check("ex_handle", {31'd0, ms_handle_ex}, 32'd1);
        check("ex_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
        check("ex_bus_flag", {31'd0, ms_to_ws_bus[151]}, 32'd1);
        tick();

        // asynchronous reset in the middle of WAIT
        do_load(mk_bus(OP_LW, 1'b1, 1'b0, 5'd10, 32'h0000_7000, 32'd0, 32'h700), 1'b1);
        #1;
        check("pre_rst_block", {31'd0, ms_fwd_block}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_allowin", {31'd0, ms_allowin}, 32'd1);
        check("async_rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("async_rst_block", {31'd0, ms_fwd_block}, 32'd0);
        check("async_rst_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between execute and writeback of the 5-stage MIPS core. It accepts the execute-stage bus, waits for the data-SRAM-like `data_ok` response of any request issued upstream, and aligns, sign-extends or merges load data for LB/LBU/LH/LHU/LW/LWL/LWR. It forwards the result to writeback, drops stale responses after an exception flush, and exports forwarding/blocking information to decode.

## Interface
- `ES_TO_MS_BUS_WD`, 161, width of execute→memory bus (field layout below)
- `MS_TO_WS_BUS_WD`, 152, width of memory→writeback bus
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `ws_allowin`  in  1  writeback can accept this cycle
- `ms_allowin`  out  1  memory stage can accept this cycle
- `es_to_ms_valid`  in  1  execute presents a valid instruction
- `es_to_ms_bus`  in  161  {ex[160], exccode[159:155], bd[154], badvaddr[153:122], eret[121], mtc0[120], cp0_addr[119:112], rt_value/cp0_wdata[111:80], res_from_cp0[79], res_from_mem[78], addr_low[77:76], lb[75], lbu[74], lh[73], lhu[72], lwl[71], lwr[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- `es_req_fire`  in  1  execute's data request was accepted (`req && addr_ok`) this cycle
- `ms_to_ws_valid`  out  1  result valid to writeback
- `ms_to_ws_bus`  out  152  {ex, exccode, bd, badvaddr, eret, mtc0, cp0_addr, cp0_wdata, res_from_cp0, gr_we, dest, final_result[63:32], pc[31:0]}
- `data_sram_rdata`  in  32  response data
- `data_sram_dataok`  in  1  one-cycle response pulse, in request order
- `ws_handle_ex`  in  1  writeback takes exception/ERET: flush
- `ms_handle_ex`  out  1  `ms_valid && (ex || eret)`
- `ms_fwd_valid`  out  1  `ms_valid && gr_we && !ex`
- `ms_fwd_dest`  out  5  destination register
- `ms_fwd_data`  out  32  forwarded value
- `ms_fwd_block`  out  1  value not yet available; decode must stall

## Operation
- Registers: `ms_valid`, bus register, `wait_data`, `data_buf_valid`, `data_buf[31:0]`, `discard_cnt[1:0]`.
- Load on `es_to_ms_valid && ms_allowin`: capture bus; `ms_valid<=1`; `wait_data<=es_req_fire`; `data_buf_valid<=0`.
- States: EMPTY (`!ms_valid`), WAIT (`ms_valid && wait_data && !data_buf_valid`), READY (otherwise).
- WAIT→READY on `data_ok` with `discard_cnt==0`: capture `data_sram_rdata` into `data_buf`; set `data_buf_valid`.
- `ms_ready_go = !wait_data || data_buf_valid || (data_ok && discard_cnt==0)`.
- `ms_allowin = !ms_valid || ms_ready_go && ws_allowin`. `ms_to_ws_valid = ms_valid && ms_ready_go`.
- Load data `ld` = `data_buf_valid ? data_buf : data_sram_rdata`. The byte `b` and halfword `h` are selected by `addr_low` (`h` uses `addr_low[1]`).
- LB sign-extends `b`; LBU zero-extends `b`; LH/LHU do the same with `h`; LW passes `ld` through.
- LWL merges with rt by `addr_low`: 0 → {ld[7:0],rt[23:0]}, 1 → {ld[15:0],rt[15:0]}, 2 → {ld[23:0],rt[7:0]}, 3 → ld.
- LWR merges with rt by `addr_low`: 0 → ld, 1 → {rt[31:24],ld[31:8]}, 2 → {rt[31:16],ld[31:16]}, 3 → {rt[31:8],ld[31:24]}.
- `final_result = res_from_mem ? load_result : alu_result`. For `res_from_cp0`, writeback supplies the value.
- Flush on `ws_handle_ex`:
  - `ms_valid<=0`, `data_buf_valid<=0`, `wait_data<=0`.
  - `discard_cnt` increments by (`ms_valid && wait_data && !data_buf_valid && !(data_ok && discard_cnt==0)`) + (`es_req_fire`). The sum is at most 2.
- Any `data_ok` while `discard_cnt!=0` decrements the counter and is ignored. Increment and decrement in the same cycle net out.
- `ms_fwd_block = ms_valid && res_from_mem && !ex && !fwd_avail`. `ms_fwd_data = final_result`.
- `ms_to_ws_bus` fields pass through unchanged except `final_result`.

## Timing
- Reset state: `ms_valid=0`, `wait_data=0`, `data_buf_valid=0`, `data_buf=0`, `discard_cnt=0`, bus register 0.
- Reset outputs: `ms_allowin=1`, `ms_to_ws_valid=0`, `ms_handle_ex=0`, `ms_fwd_valid=0`, `ms_fwd_block=0`.
- Latency is zero cycles added when `data_ok` arrives while `ws_allowin=1`: `ms_to_ws_valid` rises in the `data_ok` cycle.
- If `ws_allowin=0` at `data_ok`, the data is buffered and the stage holds. A later `data_ok` cannot belong to this instruction.
- Non-memory instructions, and instructions carrying `ex=1` with `es_req_fire=0`, are READY in the cycle after load.
- Reset asserted mid-WAIT clears everything; the pending response is not tracked after reset.

## Configuration
- `MS_LOAD_FWD_EN` defined: `fwd_avail = !wait_data || data_buf_valid || (data_ok && discard_cnt==0)`. Loaded data forwards combinationally in the `data_ok` cycle.
- `MS_LOAD_FWD_EN` undefined: `fwd_avail = !wait_data || data_buf_valid`. Decode sees the load value one cycle later, from `data_buf`. `data_buf` is always captured on an accepted `data_ok`, even when leaving the same cycle.

## Test plan
- LW, addr 0x1000, `es_req_fire=1`, `data_ok` 3 cycles later with 0xDEADBEEF, `ws_allowin=1` → `ms_to_ws_valid` in that cycle, result 0xDEADBEEF, `ms_fwd_block=1` for 2 cycles before.
- LB/LBU/LH/LHU, rdata 0x8081F2F3: LB `addr_low=1` → 0xFFFFFFF2; LBU `addr_low=3` → 0x00000080; LH `addr_low=2` → 0xFFFF8081; LHU `addr_low=0` → 0x0000F2F3.
- LWL/LWR, rt 0x11223344, rdata 0xAABBCCDD: LWL `addr_low=1` → 0xCCDD3344; LWR `addr_low=2` → 0x1122AABB.
- `data_ok` with `ws_allowin=0` for 4 cycles → data buffered, `ms_allowin=0`, result emitted when `ws_allowin` rises, value unchanged.
- Load in WAIT plus `es_req_fire`, both while `ws_handle_ex=1` → `discard_cnt=2`; next two `data_ok` ignored; a third, for a new LW, is accepted.
- Async reset pulse in mid-WAIT → all outputs at reset values immediately, without waiting for a clock edge.
